// File: rtl/mem_bus_controller.sv
// CPU data-port controller: byte/half/word sizing, lane steering, sign extension, RAM/peripheral routing.
// Optional MEMCTRL_MISALIGN_SPLIT_EN: word-crossing accesses run as two beats instead of faulting.
module mem_bus_controller #(
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 14,
  parameter int PERIPH_SEL_BIT = 16,
  parameter int PERIPH_WAIT    = 2
) (
  input  logic                      CoreClock,
  input  logic                      CoreReset,
  input  logic [ADDR_WIDTH-1:0]     CpuAddress,
  input  logic [31:0]               CpuDataWriteBus,
  input  logic                      CpuWriteAssert,
  input  logic                      CpuReadAssert,
  input  logic [1:0]                CpuSize,
  input  logic                      CpuSignExt,
  output logic [31:0]               CpuDataReadBus,
  output logic                      CpuReadOK,
  output logic                      CpuWriteOK,
  output logic                      CpuAccessFault,
  output logic [MEM_ADDR_WIDTH-1:0] AddressBus,
  output logic [31:0]               DataWriteBus,
  output logic [3:0]                ByteEnable,
  output logic                      WriteAssert,
  output logic                      ReadAssert,
  input  logic [31:0]               DataReadBus,
  output logic [MEM_ADDR_WIDTH-1:0] AddressBus_P,
  output logic [31:0]               DataWriteBus_P,
  output logic [3:0]                ByteEnable_P,
  output logic                      WriteAssert_P,
  output logic                      ReadAssert_P,
  input  logic [31:0]               DataReadBus_P
);

  typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} state_t;

  state_t                    r_state;
  logic [3:0]                r_waitCnt;
  logic [MEM_ADDR_WIDTH-1:0] r_word;
  logic [1:0]                r_off;
  logic [1:0]                r_size;
  logic                      r_sign;
  logic                      r_periph;
  logic                      r_write;
  logic                      r_fault;
  logic [MEM_ADDR_WIDTH-1:0] r_bAddr;
  logic [3:0]                r_bBe;
  logic [31:0]               r_bWd;
  logic                      r_bWr;
  logic                      r_bRd;
  logic                      r_bP;
`ifdef MEMCTRL_MISALIGN_SPLIT_EN
  logic                      r_split;
  logic [3:0]                r_be1;
  logic [31:0]               r_wd1;
  logic [31:0]               r_rdLo;
`endif

  logic                      w_req;
  logic                      w_cross;
  logic                      w_fault;
  logic                      w_periph;
  logic [1:0]                w_off;
  logic [MEM_ADDR_WIDTH-1:0] w_word;
  logic [3:0]                w_sizeMask;
  logic [31:0]               w_wdMasked;
  logic [3:0]                w_be0;
  logic [31:0]               w_wd0;
  logic [31:0]               w_rdBus;
  logic [31:0]               w_aligned;
  logic [31:0]               w_loadData;
  logic                      w_unused;

  assign w_req    = CpuWriteAssert | CpuReadAssert;
  assign w_off    = CpuAddress[1:0];
  assign w_word   = CpuAddress[MEM_ADDR_WIDTH+1:2];
  assign w_periph = CpuAddress[PERIPH_SEL_BIT];
  assign w_cross  = ((CpuSize == 2'b01) && (w_off == 2'b11)) ||
                    ((CpuSize == 2'b10) && (w_off != 2'b00));
  assign w_unused = ^CpuAddress;

  always_comb begin
    w_sizeMask = 4'b0000;
    case (CpuSize)
      2'b00:   w_sizeMask = 4'b0001;
      2'b01:   w_sizeMask = 4'b0011;
      2'b10:   w_sizeMask = 4'b1111;
      default: w_sizeMask = 4'b0000;
    endcase
  end

  assign w_wdMasked = CpuDataWriteBus & {{8{w_sizeMask[3]}}, {8{w_sizeMask[2]}},
                                         {8{w_sizeMask[1]}}, {8{w_sizeMask[0]}}};
  assign w_rdBus    = r_periph ? DataReadBus_P : DataReadBus;

  // Lanes are computed over two words so the upper half is exactly the beat1 spill-over.
`ifdef MEMCTRL_MISALIGN_SPLIT_EN
  logic [7:0]  w_beWide;
  logic [63:0] w_wdWide;
  assign w_beWide  = {4'b0000, w_sizeMask} << w_off;
  assign w_wdWide  = {32'd0, w_wdMasked} << {w_off, 3'b000};
  assign w_be0     = w_beWide[3:0];
  assign w_wd0     = w_wdWide[31:0];
  assign w_fault   = (CpuSize == 2'b11);
  assign w_aligned = 32'({(r_split ? w_rdBus : 32'd0), (r_split ? r_rdLo : w_rdBus)} >> {r_off, 3'b000});
`else
  assign w_be0     = w_sizeMask << w_off;
  assign w_wd0     = w_wdMasked << {w_off, 3'b000};
  assign w_fault   = (CpuSize == 2'b11) | w_cross;
  assign w_aligned = w_rdBus >> {r_off, 3'b000};
`endif

  function automatic logic [31:0] f_extend(input logic [31:0] d, input logic [1:0] size, input logic sign);
    logic [31:0] v;
    case (size)
      2'b00:   v = {{24{sign & d[7]}}, d[7:0]};
      2'b01:   v = {{16{sign & d[15]}}, d[15:0]};
      default: v = d;
    endcase
    return v;
  endfunction

  assign w_loadData = f_extend(w_aligned, r_size, r_sign);

  // One bus image is registered; the region bit steers it to exactly one back end.
  assign AddressBus     = r_bP ? '0 : r_bAddr;
  assign DataWriteBus   = r_bP ? '0 : r_bWd;
  assign ByteEnable     = r_bP ? '0 : r_bBe;
  assign WriteAssert    = r_bWr & ~r_bP;
  assign ReadAssert     = r_bRd & ~r_bP;
  assign AddressBus_P   = r_bP ? r_bAddr : '0;
  assign DataWriteBus_P = r_bP ? r_bWd : '0;
  assign ByteEnable_P   = r_bP ? r_bBe : '0;
  assign WriteAssert_P  = r_bWr & r_bP;
  assign ReadAssert_P   = r_bRd & r_bP;

  always_ff @(posedge CoreClock) begin
    if (CoreReset) begin
      r_state        <= IDLE;
      r_waitCnt      <= '0;
      r_word         <= '0;
      r_off          <= '0;
      r_size         <= '0;
      r_sign         <= 1'b0;
      r_periph       <= 1'b0;
      r_write        <= 1'b0;
      r_fault        <= 1'b0;
      r_bAddr        <= '0;
      r_bBe          <= '0;
      r_bWd          <= '0;
      r_bWr          <= 1'b0;
      r_bRd          <= 1'b0;
      r_bP           <= 1'b0;
      CpuDataReadBus <= '0;
      CpuReadOK      <= 1'b0;
      CpuWriteOK     <= 1'b0;
      CpuAccessFault <= 1'b0;
`ifdef MEMCTRL_MISALIGN_SPLIT_EN
      r_split        <= 1'b0;
      r_be1          <= '0;
      r_wd1          <= '0;
      r_rdLo         <= '0;
`endif
    end else begin
      r_bAddr        <= '0;
      r_bBe          <= '0;
      r_bWd          <= '0;
      r_bWr          <= 1'b0;
      r_bRd          <= 1'b0;
      r_bP           <= 1'b0;
      CpuDataReadBus <= '0;
      CpuReadOK      <= 1'b0;
      CpuWriteOK     <= 1'b0;
      CpuAccessFault <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_word   <= w_word;
            r_off    <= w_off;
            r_size   <= CpuSize;
            r_sign   <= CpuSignExt;
            r_periph <= w_periph;
            r_write  <= CpuWriteAssert;
            r_fault  <= w_fault;
`ifdef MEMCTRL_MISALIGN_SPLIT_EN
            r_split  <= w_cross & ~w_fault;
            r_be1    <= w_beWide[7:4];
            r_wd1    <= w_wdWide[63:32];
`endif
            if (!w_fault) begin
              r_bAddr <= w_word;
              r_bBe   <= w_be0;
              r_bWd   <= CpuWriteAssert ? w_wd0 : '0;
              r_bWr   <= CpuWriteAssert;
              r_bRd   <= ~CpuWriteAssert;
              r_bP    <= w_periph;
            end
            r_state <= ISSUE0;
          end
        end
        ISSUE0: begin
          if (r_fault) begin
            CpuWriteOK     <= r_write;
            CpuReadOK      <= ~r_write;
            CpuAccessFault <= 1'b1;
            r_state        <= RESP;
          end else if (r_write) begin
`ifdef MEMCTRL_MISALIGN_SPLIT_EN
            if (r_split) begin
              r_bAddr <= r_word + MEM_ADDR_WIDTH'(1);
              r_bBe   <= r_be1;
              r_bWd   <= r_wd1;
              r_bWr   <= 1'b1;
              r_bP    <= r_periph;
              r_state <= ISSUE1;
            end else
`endif
            begin
              CpuWriteOK <= 1'b1;
              r_state    <= RESP;
            end
          end else begin
            r_waitCnt <= r_periph ? 4'(PERIPH_WAIT) : 4'd0;
            r_state   <= WAIT0;
          end
        end
        WAIT0: begin
          if (r_waitCnt != 4'd0) begin
            r_waitCnt <= r_waitCnt - 4'd1;
          end else begin
`ifdef MEMCTRL_MISALIGN_SPLIT_EN
            if (r_split) begin
              r_rdLo  <= w_rdBus;
              r_bAddr <= r_word + MEM_ADDR_WIDTH'(1);
              r_bBe   <= r_be1;
              r_bRd   <= 1'b1;
              r_bP    <= r_periph;
              r_state <= ISSUE1;
            end else
`endif
            begin
              CpuReadOK      <= 1'b1;
              CpuDataReadBus <= w_loadData;
              r_state        <= RESP;
            end
          end
        end
`ifdef MEMCTRL_MISALIGN_SPLIT_EN
        ISSUE1: begin
          if (r_write) begin
            CpuWriteOK <= 1'b1;
            r_state    <= RESP;
          end else begin
            r_waitCnt <= r_periph ? 4'(PERIPH_WAIT) : 4'd0;
            r_state   <= WAIT1;
          end
        end
        WAIT1: begin
          if (r_waitCnt != 4'd0) begin
            r_waitCnt <= r_waitCnt - 4'd1;
          end else begin
            CpuReadOK      <= 1'b1;
            CpuDataReadBus <= w_loadData;
            r_state        <= RESP;
          end
        end
`endif
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
